// File: rtl/limp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : limp_pkg
//  Description : Mode codes, sequencer state encodings and the state-to-
//                actuator output decode shared by the limp actuator sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package limp_pkg;

    // Mode codes driven by the tank mode register
    localparam logic [1:0] NADA    = 2'b00;
    localparam logic [1:0] ADB     = 2'b01;
    localparam logic [1:0] LIMP    = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    // Sequencer state encodings
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DOSE  = 3'd1;
    localparam logic [2:0] DOSED = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;
    localparam logic [2:0] FILL  = 3'd5;
    localparam logic [2:0] FULL  = 3'd6;
    localparam logic [2:0] FAULT = 3'd7;

    // Actuator and status outputs, one bit each
    typedef struct packed {
        logic valve_in;
        logic valve_out;
        logic pump_adb;
        logic ve;
        logic adb_done;
        logic fault;
    } act_t;

    // Each output is a pure function of the state; the interlocks (pump only
    // with the drain closed, ve/adb_done exclusive, both valves only in FLUSH)
    // follow directly from this table.
    function automatic act_t decode_outputs(input logic [2:0] st);
        act_t a;
        a = '0;
        case (st)
            DOSE:    a.pump_adb  = 1'b1;
            DOSED:   a.adb_done  = 1'b1;
            DRAIN:   a.valve_out = 1'b1;
            FLUSH: begin
                a.valve_in  = 1'b1;
                a.valve_out = 1'b1;
            end
            FILL:    a.valve_in  = 1'b1;
            FULL:    a.ve        = 1'b1;
            FAULT:   a.fault     = 1'b1;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : level_debounce
//  Description : Accepts a new level on a raw sensor input only after DEB_CYC
//                consecutive samples that all disagree with the current level.
//                The level loads straight from the raw input during reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module level_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int              CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Count consecutive disagreeing samples; any agreeing sample restarts the run
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= i_raw;
            r_cnt   <= '0;
        end else if (i_raw == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= i_raw;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/limp_actuator_seq.sv
`default_nettype none
// ============================================================================
//  Module      : limp_actuator_seq
//  Description : Actuator-side sequencer for the tank mode register. Runs the
//                timed dosing (ADB) and drain/rinse/fill (LIMP) sequences and
//                returns tank-full / dosing-done status. Outputs are registered
//                and change on the edge that enters the state driving them.
//  Revision    : 1.0 - initial release
// ============================================================================
module limp_actuator_seq
    import limp_pkg::*;
#(
    parameter int DOSE_CYC  = 16,
    parameter int FLUSH_CYC = 32,
    parameter int DEB_CYC   = 4,
    parameter int TMO_CYC   = 1024,
    parameter int CW        = 11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       low,
    input  logic       high,
    output logic       valve_in,
    output logic       valve_out,
    output logic       pump_adb,
    output logic       ve,
    output logic       adb_done,
    output logic       fault
);

    // Terminal counts: a phase ends when the counter reaches PARAM-1
    localparam logic [CW-1:0] DOSE_LAST  = CW'(DOSE_CYC - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TMO_CYC - 1);

    logic          w_deb_low;
    logic          w_deb_high;
    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [CW-1:0] r_cnt;
    act_t          r_act;

    level_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb_low (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (low),
        .o_level (w_deb_low)
    );

    level_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb_high (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (high),
        .o_level (w_deb_high)
    );

    // Next-state: global mode overrides first, then per-phase progression.
    // Timeout is tested before the level sensor so it wins on a tie.
    always_comb begin
        w_next = r_state;
        if (mode == ILLEGAL) begin
            w_next = FAULT;
        end else if (mode == NADA) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  w_next = (mode == ADB) ? DOSE : DRAIN;
                DOSE: begin
                    if (mode != ADB)              w_next = IDLE;
                    else if (r_cnt == DOSE_LAST)  w_next = DOSED;
                end
                DOSED: begin
                    if (mode != ADB)              w_next = IDLE;
                end
                DRAIN: begin
                    if (mode != LIMP)             w_next = IDLE;
                    else if (r_cnt == TMO_LAST)   w_next = FAULT;
                    else if (w_deb_low)           w_next = FLUSH;
                end
                FLUSH: begin
                    if (mode != LIMP)             w_next = IDLE;
                    else if (r_cnt == FLUSH_LAST) w_next = FILL;
                end
                FILL: begin
                    if (mode != LIMP)             w_next = IDLE;
                    else if (r_cnt == TMO_LAST)   w_next = FAULT;
                    else if (w_deb_high)          w_next = FULL;
                end
                FULL: begin
                    if (mode != LIMP)             w_next = IDLE;
                end
                FAULT:   w_next = FAULT;
                default: w_next = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Shared phase/timeout counter: clears on every state entry, saturates
    always_ff @(posedge clock) begin
        if (reset)                   r_cnt <= '0;
        else if (w_next != r_state)  r_cnt <= '0;
        else if (r_cnt != {CW{1'b1}}) r_cnt <= r_cnt + CW'(1);
    end

    // Outputs decoded from the state being entered, so they move with it
    always_ff @(posedge clock) begin
        if (reset) r_act <= '0;
        else       r_act <= decode_outputs(w_next);
    end

    assign valve_in  = r_act.valve_in;
    assign valve_out = r_act.valve_out;
    assign pump_adb  = r_act.pump_adb;
    assign ve        = r_act.ve;
    assign adb_done  = r_act.adb_done;
    assign fault     = r_act.fault;

endmodule
`default_nettype wire

// File: tb/tb_limp_actuator_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_limp_actuator_seq
//  Description : Self-checking bench for limp_actuator_seq. A driver issues
//                directed and random mode/sensor stimulus and pushes the
//                expected outputs from a behavioural model into a queue; a
//                monitor pops and compares after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_limp_actuator_seq;

    localparam int DOSE_CYC  = 4;
    localparam int FLUSH_CYC = 3;
    localparam int DEB_CYC   = 2;
    localparam int TMO_CYC   = 20;
    localparam int CW        = 11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode  = 2'b01;
    logic       low   = 1'b0;
    logic       high  = 1'b0;
    wire        valve_in, valve_out, pump_adb, ve, adb_done, fault;

    limp_actuator_seq #(
        .DOSE_CYC  (DOSE_CYC),
        .FLUSH_CYC (FLUSH_CYC),
        .DEB_CYC   (DEB_CYC),
        .TMO_CYC   (TMO_CYC),
        .CW        (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .low       (low),
        .high      (high),
        .valve_in  (valve_in),
        .valve_out (valve_out),
        .pump_adb  (pump_adb),
        .ve        (ve),
        .adb_done  (adb_done),
        .fault     (fault)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef enum int {P_OFF, P_DOSING, P_DOSED, P_DRAINING, P_RINSING,
                      P_FILLING, P_FULL, P_FAULTED} phase_t;

    phase_t     ph = P_OFF;
    int         ticks = 0;        // edges spent in the current phase, entry edge = 1
    bit         lvl_low = 1'b0;   // accepted sensor levels as seen before this edge
    bit         lvl_high = 1'b0;
    bit         low_hist[$];
    bit         high_hist[$];
    logic [5:0] exp_q[$];         // {valve_in, valve_out, pump_adb, ve, adb_done, fault}

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [5:0] outputs_of(phase_t p);
        case (p)
            P_DOSING:   return 6'b001000;
            P_DOSED:    return 6'b000010;
            P_DRAINING: return 6'b010000;
            P_RINSING:  return 6'b110000;
            P_FILLING:  return 6'b100000;
            P_FULL:     return 6'b000100;
            P_FAULTED:  return 6'b000001;
            default:    return 6'b000000;
        endcase
    endfunction

    // A level is accepted once the last DEB_CYC raw samples all agree
    task automatic debounce_sample(input bit s, inout bit hist[$], inout bit lvl);
        bit all_same;
        hist.push_back(s);
        if (hist.size() > DEB_CYC) void'(hist.pop_front());
        all_same = (hist.size() == DEB_CYC);
        foreach (hist[i]) if (hist[i] != s) all_same = 1'b0;
        if (all_same) lvl = s;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled
    task automatic model_edge();
        phase_t nx;
        if (reset) begin
            ph = P_OFF;
            ticks = 0;
            low_hist.delete();
            high_hist.delete();
            low_hist.push_back(low);
            high_hist.push_back(high);
            lvl_low  = low;
            lvl_high = high;
        end else begin
            nx = ph;
            if (mode == 2'b11)      nx = P_FAULTED;
            else if (mode == 2'b00) nx = P_OFF;
            else begin
                case (ph)
                    P_FAULTED:  nx = P_FAULTED;
                    P_OFF:      nx = (mode == 2'b01) ? P_DOSING : P_DRAINING;
                    P_DOSING:   if (mode != 2'b01) nx = P_OFF;
                                else if (ticks == DOSE_CYC) nx = P_DOSED;
                    P_DOSED:    if (mode != 2'b01) nx = P_OFF;
                    P_DRAINING: if (mode != 2'b10) nx = P_OFF;
                                else if (ticks == TMO_CYC) nx = P_FAULTED;
                                else if (lvl_low) nx = P_RINSING;
                    P_RINSING:  if (mode != 2'b10) nx = P_OFF;
                                else if (ticks == FLUSH_CYC) nx = P_FILLING;
                    P_FILLING:  if (mode != 2'b10) nx = P_OFF;
                                else if (ticks == TMO_CYC) nx = P_FAULTED;
                                else if (lvl_high) nx = P_FULL;
                    P_FULL:     if (mode != 2'b10) nx = P_OFF;
                    default:    nx = P_OFF;
                endcase
            end
            ticks = (nx != ph) ? 1 : ticks + 1;
            ph = nx;
            debounce_sample(low,  low_hist,  lvl_low);
            debounce_sample(high, high_hist, lvl_high);
        end
        exp_q.push_back(reset ? 6'b000000 : outputs_of(ph));
    endtask

    // ---------------- driver ----------------
    task automatic hold(input logic r, input logic [1:0] m, input logic l,
                        input logic h, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            reset = r;
            mode  = m;
            low   = l;
            high  = h;
            model_edge();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valve_in",  valve_in,  e[5]);
                check("valve_out", valve_out, e[4]);
                check("pump_adb",  pump_adb,  e[3]);
                check("ve",        ve,        e[2]);
                check("adb_done",  adb_done,  e[1]);
                check("fault",     fault,     e[0]);
                check("ilock_pump_drain", pump_adb & valve_out, 1'b0);
                check("ilock_ve_done",    ve & adb_done,        1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] m;
        logic       l, h;
        int         len, pick;

        // Reset held with ADB requested, then dosing runs to completion
        hold(1'b1, 2'b01, 1'b0, 1'b0, 3);
        hold(1'b0, 2'b01, 1'b0, 1'b0, 8);
        hold(1'b0, 2'b00, 1'b0, 1'b0, 2);

        // Full LIMP sequence: low rises from cycle 5, then high
        hold(1'b0, 2'b10, 1'b0, 1'b0, 4);
        hold(1'b0, 2'b10, 1'b1, 1'b0, 10);
        hold(1'b0, 2'b10, 1'b1, 1'b1, 6);
        hold(1'b0, 2'b00, 1'b0, 1'b0, 3);

        // Drain timeout, fault held through non-zero modes, cleared by NADA
        hold(1'b0, 2'b10, 1'b0, 1'b0, 24);
        hold(1'b0, 2'b01, 1'b0, 1'b0, 2);
        hold(1'b0, 2'b00, 1'b0, 1'b0, 2);

        // Abort during FLUSH, then restart from DRAIN
        hold(1'b0, 2'b00, 1'b1, 1'b0, 3);
        hold(1'b0, 2'b10, 1'b1, 1'b0, 2);
        hold(1'b0, 2'b00, 1'b1, 1'b0, 1);
        hold(1'b0, 2'b10, 1'b1, 1'b0, 6);
        hold(1'b0, 2'b00, 1'b0, 1'b0, 2);

        // Illegal code from DOSED, then a one-cycle low glitch during DRAIN
        hold(1'b0, 2'b01, 1'b0, 1'b0, 6);
        hold(1'b0, 2'b11, 1'b0, 1'b0, 2);
        hold(1'b0, 2'b00, 1'b0, 1'b0, 1);
        hold(1'b0, 2'b10, 1'b0, 1'b0, 3);
        hold(1'b0, 2'b10, 1'b1, 1'b0, 1);
        hold(1'b0, 2'b10, 1'b0, 1'b0, 4);
        hold(1'b0, 2'b00, 1'b0, 1'b0, 2);

        // Random segments: mode held for a random length, sensors toggle sparsely
        l = 1'b0;
        h = 1'b0;
        for (int s = 0; s < 80; s++) begin
            pick = int'($urandom_range(0, 9));
            if (pick == 0)      m = 2'b00;
            else if (pick <= 3) m = 2'b01;
            else if (pick <= 8) m = 2'b10;
            else                m = 2'b11;
            len = int'($urandom_range(1, 30));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0) l = ~l;
                if ($urandom_range(0, 7) == 0) h = ~h;
                hold(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, m, l, h, 1);
            end
        end

        hold(1'b0, 2'b00, 1'b0, 1'b0, 2);
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
